tanh_pipe: RTL and testbench

//  Pipelined, handshaked fixed-point tanh activation for the NN datapath.

---
 rtl/act_pkg.sv | 32 +++
 rtl/tanh_seg_lut.sv | 44 ++++
 rtl/tanh_pipe.sv | 139 +++++++++++++
 tb/tb_tanh_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared constants for the fixed-point activation pipeline: default widths, segment
// enum, thresholds and the piecewise-quadratic coefficient table (at DEF_FL).
package act_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FL    = 24;

  typedef enum logic [1:0] {SEG0, SEG1, SEG2, SEG3} seg_e;

  // Round-to-nearest (ties away from zero) of c * 2^DEF_FL.
  function automatic longint coef(input real c);
    real s;
    s = c * real'(longint'(1) << DEF_FL);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    else          return -longint'($rtoi(-s + 0.5));
  endfunction

  // Re-expresses a DEF_FL constant with fl fractional bits.
  function automatic longint rescale(input longint v, input int fl);
    if (fl >= DEF_FL) return v <<< (fl - DEF_FL);
    else              return v >>> (DEF_FL - fl);
  endfunction

  localparam longint ONE  = longint'(1) << DEF_FL;
  localparam longint TWO  = ONE << 1;
  localparam longint FOUR = ONE << 2;

  localparam longint P1 [4] = '{coef(-0.312854), coef(-0.168637), coef(-0.012845), coef(0.0)};
  localparam longint P2 [4] = '{coef(1.079009),  coef(0.699828),  coef(0.091424),  coef(0.0)};
  localparam longint P3 [4] = '{coef(0.0),       coef(0.234964),  coef(0.836701),  coef(1.0)};

endpackage

// File: rtl/tanh_seg_lut.sv
// Combinational segment selector: non-negative magnitude ai -> segment and its
// (p1, p2, p3) coefficients at FL fractional bits.
module tanh_seg_lut
  import act_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FL    = DEF_FL
) (
  input  logic [WIDTH-1:0]        ai_i,
  output seg_e                    seg_o,
  output logic signed [WIDTH-1:0] p1_o,
  output logic signed [WIDTH-1:0] p2_o,
  output logic signed [WIDTH-1:0] p3_o
);

  localparam logic [WIDTH-1:0] TH_ONE  = WIDTH'(rescale(ONE, FL));
  localparam logic [WIDTH-1:0] TH_TWO  = WIDTH'(rescale(TWO, FL));
  localparam logic [WIDTH-1:0] TH_FOUR = WIDTH'(rescale(FOUR, FL));

  logic signed [WIDTH-1:0] p1_tab [4];
  logic signed [WIDTH-1:0] p2_tab [4];
  logic signed [WIDTH-1:0] p3_tab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tab
      assign p1_tab[gi] = WIDTH'(rescale(P1[gi], FL));
      assign p2_tab[gi] = WIDTH'(rescale(P2[gi], FL));
      assign p3_tab[gi] = WIDTH'(rescale(P3[gi], FL));
    end
  endgenerate

  always_comb begin
    seg_o = SEG0;
    if (ai_i >= TH_FOUR)     seg_o = SEG3;
    else if (ai_i >= TH_TWO) seg_o = SEG2;
    else if (ai_i >= TH_ONE) seg_o = SEG1;
  end

  assign p1_o = p1_tab[seg_o];
  assign p2_o = p2_tab[seg_o];
  assign p3_o = p3_tab[seg_o];

endmodule

// File: rtl/tanh_pipe.sv
// Three-stage valid/ready fixed-point tanh (piecewise quadratic, odd symmetry, clamped).
// Optional macro ACT_SIGMOID_EN adds a per-sample sigmoid mode via tanh(x/2).
module tanh_pipe
  import act_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FL    = DEF_FL,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_V = ~MIN_V;
  localparam logic signed [WIDTH+1:0] ONE_S = (WIDTH+2)'(rescale(ONE, FL));

  logic adv;

  // Stage 1 state
  logic                    v1_q, sign1_q;
  logic [TAG_W-1:0]        tag1_q;
  logic signed [WIDTH-1:0] ai1_q, sq1_q, p1_1_q, p2_1_q, p3_1_q;
  // Stage 2 state
  logic                    v2_q, sign2_q;
  logic [TAG_W-1:0]        tag2_q;
  logic signed [WIDTH-1:0] ta2_q, tb2_q, p3_2_q;
  // Stage 3 (output) state
  logic                    out_valid_q;
  logic signed [WIDTH-1:0] out_data_q;
  logic [TAG_W-1:0]        out_tag_q;

  // Stage 1 combinational
  logic signed [WIDTH-1:0]   x_s, ai_d, sq_d, p1_d, p2_d, p3_d;
  logic signed [2*WIDTH-1:0] sq_full;
  logic                      sign_d;
  seg_e                      seg_d;

  // Stage 2/3 combinational
  logic signed [2*WIDTH-1:0] prod_a, prod_b;
  logic signed [WIDTH+1:0]   sum, y_abs, y_tanh, y_fin;
  logic signed [WIDTH-1:0]   out_data_d;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;

`ifdef ACT_SIGMOID_EN
  logic mode1_q, mode2_q;
  assign x_s = mode ? (in_data >>> 1) : in_data;
`else
  logic mode_unused;
  assign mode_unused = mode;
  assign x_s         = in_data;
`endif

  assign sign_d = x_s[WIDTH-1];
  assign ai_d   = (x_s == MIN_V) ? MAX_V : (sign_d ? -x_s : x_s);

  tanh_seg_lut #(.WIDTH(WIDTH), .FL(FL)) u_lut (
    .ai_i  (ai_d),
    .seg_o (seg_d),
    .p1_o  (p1_d),
    .p2_o  (p2_d),
    .p3_o  (p3_d)
  );

  // The top segment is a constant, so skipping its square avoids overflow for large ai.
  assign sq_full = (2*WIDTH)'(ai_d) * (2*WIDTH)'(ai_d);
  assign sq_d    = (seg_d == SEG3) ? '0 : sq_full[FL+WIDTH-1:FL];

  assign prod_a = (2*WIDTH)'(p1_1_q) * (2*WIDTH)'(sq1_q);
  assign prod_b = (2*WIDTH)'(p2_1_q) * (2*WIDTH)'(ai1_q);

  always_comb begin
    sum   = (WIDTH+2)'(ta2_q) + (WIDTH+2)'(tb2_q) + (WIDTH+2)'(p3_2_q);
    y_abs = sum;
    if (sum < 0)          y_abs = '0;
    else if (sum > ONE_S) y_abs = ONE_S;
    y_tanh = sign2_q ? -y_abs : y_abs;
`ifdef ACT_SIGMOID_EN
    y_fin = mode2_q ? ((ONE_S + y_tanh) >>> 1) : y_tanh;
`else
    y_fin = y_tanh;
`endif
    out_data_d = y_fin[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      out_data_q  <= out_data_d;
      out_tag_q   <= tag2_q;
    end
  end

  // Datapath registers need no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q <= sign_d;
      tag1_q  <= in_tag;
      ai1_q   <= ai_d;
      sq1_q   <= sq_d;
      p1_1_q  <= p1_d;
      p2_1_q  <= p2_d;
      p3_1_q  <= p3_d;
      sign2_q <= sign1_q;
      tag2_q  <= tag1_q;
      ta2_q   <= prod_a[FL+WIDTH-1:FL];
      tb2_q   <= prod_b[FL+WIDTH-1:FL];
      p3_2_q  <= p3_1_q;
`ifdef ACT_SIGMOID_EN
      mode1_q <= mode;
      mode2_q <= mode1_q;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_tanh_pipe.sv
// Directed self-checking bench for tanh_pipe (Q8.24); sigmoid checks only when
// ACT_SIGMOID_EN is defined.
module tb_tanh_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_tag;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed vectors: Q8.24 input and expected output.
  logic [31:0] vin  [10] = '{32'h00000000, 32'h01000000, 32'hFF000000, 32'h00800000, 32'hFF800000,
                             32'h03000000, 32'hFD000000, 32'h02000000, 32'h05000000, 32'h80000000};
  logic [31:0] vexp [10] = '{32'h00000000, 32'h00C422BD, 32'hFF3BDD43, 32'h0076172A, 32'hFF89E8D6,
                             32'h00FED072, 32'hFF012F8E, 32'h00F7D9ED, 32'h01000000, 32'hFF000000};

  tanh_pipe #(.WIDTH(32), .FL(24), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one sample on an empty pipe, checks 3-cycle latency, data and tag.
  task automatic run_vec(input logic [31:0] x, input logic [7:0] tag, input logic m,
                         input logic [31:0] exp_d, input string name);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    in_tag    = tag;
    mode      = m;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want 3", name, lat);
    end
    n_tests++;
    if (out_data !== exp_d || out_tag !== tag) begin
      n_fail++;
      $display("FAIL %s: got data %h tag %h want data %h tag %h", name, out_data, out_tag, exp_d, tag);
    end
    $display("[TB] %s x=%h y=%h tag=%h", name, x, out_data, out_tag);
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) tick;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h t=%h want v=0 d=0 t=0", out_valid, out_data, out_tag);
    end
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 8; i++) run_vec(vin[i], 8'(8'h10 + i), 1'b0, vexp[i], $sformatf("basic%0d", i));
  endtask

  task automatic test_boundaries;
    run_vec(32'h05000000, 8'h21, 1'b0, 32'h01000000, "pos_sat");
    run_vec(32'hFB000000, 8'h22, 1'b0, 32'hFF000000, "neg_sat");
    run_vec(32'h80000000, 8'h23, 1'b0, 32'hFF000000, "most_neg");
    run_vec(32'h7FFFFFFF, 8'h24, 1'b0, 32'h01000000, "most_pos");
    run_vec(32'h04000000, 8'h25, 1'b0, 32'h01000000, "seg3_edge");
  endtask

  task automatic test_mode;
`ifdef ACT_SIGMOID_EN
    run_vec(32'h00000000, 8'h31, 1'b1, 32'h00800000, "sig_zero");
    run_vec(32'h0A000000, 8'h32, 1'b1, 32'h01000000, "sig_pos");
    run_vec(32'hF6000000, 8'h33, 1'b1, 32'h00000000, "sig_neg");
    run_vec(32'h01000000, 8'h34, 1'b0, 32'h00C422BD, "sig_off");
`else
    run_vec(32'h01000000, 8'h31, 1'b1, 32'h00C422BD, "mode_ignored");
`endif
  endtask

  task automatic test_back_to_back;
    int idx [20];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    for (int i = 0; i < 20; i++) idx[i] = int'($urandom_range(0, 9));
    while (got < 20 && cyc < 200) begin
      out_ready = !(cyc >= 10 && cyc < 15);
      mode = 1'b0;
      if (sent < 20) begin
        in_valid = 1'b1;
        in_data  = vin[idx[sent]];
        in_tag   = 8'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_tag !== 8'(got) || out_data !== vexp[idx[got]]) begin
          n_fail++;
          $display("FAIL stream_out: got tag %0d data %h want tag %0d data %h",
                   out_tag, out_data, got, vexp[idx[got]]);
        end
        $display("[TB] stream tag=%0d y=%h", out_tag, out_data);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 20 || cyc != 28) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results in %0d cycles want 20 in 28", got, cyc);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i + 1];
      in_tag   = 8'(8'h40 + i);
      tick;
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_flush: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_leftover: cycle %0d got v=%b want 0", i, out_valid);
      end
    end
    run_vec(32'h05000000, 8'h55, 1'b0, 32'h01000000, "post_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_mode;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
